// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared definitions for the SDRAM request arbiter
// (FSM state encoding, channel-count limits, width helpers).
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    localparam int unsigned NUM_CH_MIN = 2;
    localparam int unsigned NUM_CH_MAX = 8;
    localparam int unsigned IDX_W_MAX  = $clog2(NUM_CH_MAX);

    // $clog2 that never yields a zero-width vector
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder over channels 1..NUM_CH-1.
// The search starts just after the last-granted channel and wraps from
// NUM_CH-1 back to 1; channel 0 is never considered here.
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 3
)
(
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] ptr,
    output logic [$clog2(NUM_CH)-1:0] idx,
    output logic                      valid
);

    localparam int unsigned IDX_W = clog2_min1(NUM_CH);

    // Walk the search order backwards so the earliest candidate assigns last
    always_comb begin
        int unsigned c;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned k = NUM_CH - 1; k > 0; k--) begin
            c = ((int'(ptr) + k + NUM_CH - 2) % (NUM_CH - 1)) + 1;
            if (req[c]) begin
                idx   = IDX_W'(c);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: serialises NUM_CH masters onto one SDRAM controller port
// with a registered req/ack handshake. Channel 0 always wins; channels
// 1..NUM_CH-1 use fixed priority (lowest index) by default, or round robin
// when the macro SDRAM_ARB_RR_EN is defined. A watchdog aborts accesses
// that see no mem_ack within TIMEOUT_CYC cycles (0 disables it).
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1023
)
(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_din,
    output logic [NUM_CH-1:0]          ch_ack,
    output logic                       ch_err,
    output logic [DATA_W-1:0]          ch_dout,
    output logic [$clog2(NUM_CH)-1:0]  grant_idx,
    output logic                       busy,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_din,
    input  logic                       mem_ack,
    input  logic [DATA_W-1:0]          mem_dout
);

    localparam int unsigned    IDX_W    = clog2_min1(NUM_CH);
    localparam int unsigned    WD_W     = clog2_min1(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

    arb_state_t          state, state_n;
    logic [NUM_CH-1:0]   ch_ack_n;
    logic                ch_err_n;
    logic [DATA_W-1:0]   ch_dout_n;
    logic [IDX_W-1:0]    grant_idx_n;
    logic                mem_req_n;
    logic                mem_we_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_din_n;
    logic [WD_W-1:0]     wd, wd_n;
    logic [IDX_W-1:0]    winner;
    logic                timeout_hit;

    assign busy        = (state != IDLE);
    assign timeout_hit = (TIMEOUT_CYC != 0) && ((wd + WD_W'(1)) == WD_LIMIT);

`ifdef SDRAM_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_valid;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .req   (ch_req),
        .ptr   (rr_ptr),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    // Channel 0 overrides the round-robin choice
    always_comb begin
        winner = ch_req[0] ? '0 : rr_idx;
    end

    // Pointer follows grants to channels 1..NUM_CH-1 only
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            rr_ptr <= IDX_W'(NUM_CH - 1);
        else if (state == IDLE && !ch_req[0] && rr_valid)
            rr_ptr <= rr_idx;
    end
`else
    // Fixed priority: lowest requesting index wins
    always_comb begin
        winner = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (ch_req[i-1]) winner = IDX_W'(i - 1);
        end
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_n     = state;
        ch_ack_n    = '0;
        ch_err_n    = ch_err;
        ch_dout_n   = ch_dout;
        grant_idx_n = grant_idx;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_din_n   = mem_din;
        wd_n        = wd;
        case (state)
            IDLE: begin
                if (|ch_req) begin
                    grant_idx_n = winner;
                    mem_we_n    = ch_we[winner];
                    mem_addr_n  = ch_addr[int'(winner)*ADDR_W +: ADDR_W];
                    mem_din_n   = ch_din[int'(winner)*DATA_W +: DATA_W];
                    mem_req_n   = 1'b1;
                    wd_n        = '0;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                if (wd != WD_LIMIT) wd_n = wd + WD_W'(1);
                // mem_ack is checked first so it wins a same-cycle timeout
                if (mem_ack) begin
                    if (!mem_we) ch_dout_n = mem_dout;
                    mem_req_n           = 1'b0;
                    ch_ack_n[grant_idx] = 1'b1;
                    state_n             = ACK;
                end else if (timeout_hit) begin
                    mem_req_n           = 1'b0;
                    ch_err_n            = 1'b1;
                    ch_ack_n[grant_idx] = 1'b1;
                    state_n             = ACK;
                end
            end
            ACK: begin
                ch_err_n = 1'b0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // Output and watchdog registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ch_ack    <= '0;
            ch_err    <= 1'b0;
            ch_dout   <= '0;
            grant_idx <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            wd        <= '0;
        end else begin
            ch_ack    <= ch_ack_n;
            ch_err    <= ch_err_n;
            ch_dout   <= ch_dout_n;
            grant_idx <= grant_idx_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_din   <= mem_din_n;
            wd        <= wd_n;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: self-checking bench for sdram_arbiter (NUM_CH=4,
// TIMEOUT_CYC=15). Follows SDRAM_ARB_RR_EN for the expected grant order.
module tb_sdram_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 25;
    localparam int DW  = 8;
    localparam int TO  = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_we;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_din;
    logic [NCH-1:0]    ch_ack;
    logic              ch_err;
    logic [DW-1:0]     ch_dout;
    logic [1:0]        grant_idx;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic              mem_ack;
    logic [DW-1:0]     mem_dout;

    sdram_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .CLK(clk), .RST(rst),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_din(ch_din),
        .ch_ack(ch_ack), .ch_err(ch_err), .ch_dout(ch_dout), .grant_idx(grant_idx),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_ack(mem_ack), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Requester-side view of each channel
    bit          req_v  [NCH];
    logic        we_v   [NCH];
    logic [AW-1:0] addr_v [NCH];
    logic [DW-1:0] din_v  [NCH];
    logic [DW-1:0] last_dout;
`ifdef SDRAM_ARB_RR_EN
    int rr_order[$];
`endif

    typedef struct {
        int          ch;
        logic        we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        int          lat;
        logic [DW-1:0] rdata;
        logic        exp_err;
        logic [DW-1:0] exp_dout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            ch_req[i]             = req_v[i];
            ch_we[i]              = we_v[i];
            ch_addr[i*AW +: AW]   = addr_v[i];
            ch_din[i*DW +: DW]    = din_v[i];
        end
    endtask

    task automatic set_req(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_v[c] = 1'b1; we_v[c] = we; addr_v[c] = a; din_v[c] = d;
        drive();
    endtask

    // Model: service order list; a grant moves the winner to the back of the list
    task automatic model_reset();
        last_dout = '0;
`ifdef SDRAM_ARB_RR_EN
        rr_order = {};
        for (int c = 1; c < NCH; c++) rr_order.push_back(c);
`endif
    endtask

    function automatic int model_winner();
        if (req_v[0]) return 0;
`ifdef SDRAM_ARB_RR_EN
        foreach (rr_order[i]) if (req_v[rr_order[i]]) return rr_order[i];
`else
        for (int c = 1; c < NCH; c++) if (req_v[c]) return c;
`endif
        return -1;
    endfunction

    task automatic model_grant(input int c);
`ifdef SDRAM_ARB_RR_EN
        int x;
        if (c > 0) begin
            do begin
                x = rr_order.pop_front();
                rr_order.push_back(x);
            end while (x != c);
        end
`else
        if (c < 0) $display("model_grant: no channel");
`endif
    endtask

    function automatic bit any_pending();
        for (int c = 0; c < NCH; c++) if (req_v[c]) return 1'b1;
        return 1'b0;
    endfunction

    // One complete access: grant, memory response after lat cycles (0 = never), ack
    task automatic serve(input int lat, input logic [DW-1:0] rdata,
                         output int got_grant, output logic got_err, output logic [DW-1:0] got_dout);
        int w; int cnt; bit held; bit done;
        logic exp_err; logic [DW-1:0] exp_dout;
        got_grant = -1; got_err = 1'b0; got_dout = '0;
        w = model_winner();
        if (w < 0) begin
            checks++; failures++;
            $display("FAIL serve_no_request: got none expected a pending channel");
            return;
        end
        exp_err  = (lat == 0);
        exp_dout = (!we_v[w] && !exp_err) ? rdata : last_dout;
        @(negedge clk);
        check("mem_req_rise", {31'd0, mem_req}, 1);
        check("busy_issue", {31'd0, busy}, 1);
        check("grant_idx", {30'd0, grant_idx}, w);
        check("mem_we", {31'd0, mem_we}, {31'd0, we_v[w]});
        check("mem_addr", {7'd0, mem_addr}, {7'd0, addr_v[w]});
        check("mem_din", {24'd0, mem_din}, {24'd0, din_v[w]});
        held = 1; cnt = 0; done = 0;
        while (!done) begin
            cnt++;
            if (cnt == lat) begin mem_ack = 1'b1; mem_dout = rdata; end
            @(negedge clk);
            mem_ack = 1'b0;
            if (cnt == lat || cnt == TO) done = 1;
            else if (!mem_req || grant_idx != 2'(w) || mem_addr != addr_v[w] || ch_ack != '0) held = 0;
        end
        check("issue_held", {31'd0, held}, 1);
        check("ch_ack_pulse", {28'd0, ch_ack}, 32'(1 << w));
        check("ch_err", {31'd0, ch_err}, {31'd0, exp_err});
        check("ch_dout", {24'd0, ch_dout}, {24'd0, exp_dout});
        check("mem_req_drop", {31'd0, mem_req}, 0);
        got_grant = int'(grant_idx); got_err = ch_err; got_dout = ch_dout;
        req_v[w] = 1'b0;
        drive();
        model_grant(w);
        last_dout = exp_dout;
        @(negedge clk);
        check("ch_ack_clear", {28'd0, ch_ack}, 0);
        check("ch_err_clear", {31'd0, ch_err}, 0);
        check("busy_idle", {31'd0, busy}, 0);
    endtask

    task automatic drain();
        int g; logic e; logic [DW-1:0] d;
        while (any_pending()) serve(2, DW'($urandom), g, e, d);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before limit");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t tbl[8];
        int   rr_exp[6];
        int   g; logic e; logic [DW-1:0] d;
        int   n0;

        tbl[0] = '{1, 1'b0, 25'h0_1234, 8'h00, 4,  8'hA5, 1'b0, 8'hA5};
        tbl[1] = '{2, 1'b1, 25'h1_0F0F, 8'h77, 1,  8'hEE, 1'b0, 8'hA5};
        tbl[2] = '{3, 1'b0, 25'h0_0042, 8'h00, 0,  8'h99, 1'b1, 8'hA5};
        tbl[3] = '{1, 1'b0, 25'h1F_FFFF, 8'h00, 15, 8'h5A, 1'b0, 8'h5A};
        tbl[4] = '{0, 1'b0, 25'h0_0000, 8'h00, 1,  8'hC3, 1'b0, 8'hC3};
        tbl[5] = '{2, 1'b0, 25'h0_8000, 8'h00, 2,  8'h00, 1'b0, 8'h00};
        tbl[6] = '{3, 1'b1, 25'h0_0003, 8'h12, 0,  8'hFF, 1'b1, 8'h00};
        tbl[7] = '{0, 1'b1, 25'h1_2345, 8'h34, 3,  8'h66, 1'b0, 8'h00};
`ifdef SDRAM_ARB_RR_EN
        rr_exp = '{1, 2, 3, 1, 2, 3};
`else
        rr_exp = '{1, 1, 1, 1, 1, 1};
`endif

        for (int c = 0; c < NCH; c++) begin req_v[c] = 0; we_v[c] = 0; addr_v[c] = '0; din_v[c] = '0; end
        drive();
        mem_ack = 1'b0; mem_dout = '0;
        model_reset();

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ch_ack", {28'd0, ch_ack}, 0);
        check("rst_ch_err", {31'd0, ch_err}, 0);
        check("rst_mem_req", {31'd0, mem_req}, 0);
        check("rst_mem_we", {31'd0, mem_we}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_mem_addr", {7'd0, mem_addr}, 0);
        check("rst_mem_din", {24'd0, mem_din}, 0);
        check("rst_ch_dout", {24'd0, ch_dout}, 0);
        check("rst_grant_idx", {30'd0, grant_idx}, 0);
        rst = 1'b0;

        // Channels 1..3 held continuously from reset
        for (int c = 1; c < NCH; c++) set_req(c, 1'b0, AW'(32'h100 + c), 8'h00);
        for (int i = 0; i < 6; i++) begin
            serve(2, DW'(8'h10 + i), g, e, d);
            check("rr_order", g, rr_exp[i]);
            for (int c = 1; c < NCH; c++) req_v[c] = 1'b1;
            drive();
        end
        drain();

        // Channel 0 streams 8 writes while channels 1 and 2 wait
        set_req(1, 1'b0, 25'h0_0111, 8'h00);
        set_req(2, 1'b0, 25'h0_0222, 8'h00);
        n0 = 0;
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1'b1, AW'(32'h2000 + k), DW'(8'hB0 + k));
            serve(1, 8'h00, g, e, d);
            if (g == 0) n0++;
        end
        check("ch0_grants", n0, 8);
        drain();

        // Table of single-channel accesses
        for (int i = 0; i < 8; i++) begin
            set_req(tbl[i].ch, tbl[i].we, tbl[i].addr, tbl[i].din);
            serve(tbl[i].lat, tbl[i].rdata, g, e, d);
            check("tbl_grant", g, tbl[i].ch);
            check("tbl_err", {31'd0, e}, {31'd0, tbl[i].exp_err});
            check("tbl_dout", {24'd0, d}, {24'd0, tbl[i].exp_dout});
        end

        // Reset asserted mid-access
        set_req(2, 1'b0, 25'h0_ABCD, 8'h00);
        @(negedge clk);
        check("mid_mem_req", {31'd0, mem_req}, 1);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_mem_req", {31'd0, mem_req}, 0);
        check("async_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        serve(2, 8'h3C, g, e, d);
        check("post_rst_grant", g, 2);
        check("post_rst_dout", {24'd0, d}, 32'h3C);

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            int r; int lat;
            for (int c = 0; c < NCH; c++)
                if (!req_v[c] && $urandom_range(0, 1) == 1)
                    set_req(c, 1'($urandom), AW'($urandom), DW'($urandom));
            if (!any_pending())
                set_req(int'($urandom_range(0, NCH - 1)), 1'($urandom), AW'($urandom), DW'($urandom));
            r   = int'($urandom_range(0, 9));
            lat = (r == 0) ? 0 : (r == 1) ? TO : int'($urandom_range(1, 5));
            serve(lat, DW'($urandom), g, e, d);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
